rf_read_arbiter: RTL and testbench

RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

---
 rtl/rf_read_arbiter_pkg.sv | 15 +
 rtl/rf_read_arbiter_if.sv | 34 +++
 rtl/rf_read_arbiter_rr_arbiter.sv | 30 +++
 rtl/rf_read_arbiter.sv | 103 ++++++++++
 tb/tb_rf_read_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_read_arbiter_pkg.sv
// Shared constants for the register-file read-port arbiter.
// Requester-ID width is derived from the requester count.
package rf_read_arbiter_pkg;

    localparam int RF_NREQ = 4;
    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RF_IDW = id_width(RF_NREQ);

endpackage

// File: rtl/rf_read_arbiter_if.sv
// Request/response bundle between requesters and the read arbiter.
// Addresses are flat-packed, requester i at [i*AW +: AW].
interface rf_read_arbiter_if #(
    parameter int NREQ = rf_read_arbiter_pkg::RF_NREQ,
    parameter int AW   = rf_read_arbiter_pkg::RF_AW,
    parameter int DW   = rf_read_arbiter_pkg::RF_DW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_data;
    logic [NREQ-1:0]    resp_ready;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        output resp_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        input  resp_ready
    );

endinterface

// File: rtl/rf_read_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: search starts at ptr and wraps.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter
    import rf_read_arbiter_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Three-stage shared read port: arbitrate/accept, mux read, respond.
// A held response freezes the whole pipe and blocks new acceptances.
module rf_read_arbiter
    import rf_read_arbiter_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                clk,
    input  logic                reset,
    rf_read_arbiter_if.slave    bus,
    output logic [AW-1:0]       rd_sel,
    input  logic [DW-1:0]       rd_data
);

    localparam int IDW = id_width(NREQ);

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic [AW-1:0]   gaddr;
    logic            accept;
    logic            stall;

    logic            r_valid;
    logic [IDW-1:0]  r_id;
    logic            p_valid;
    logic [IDW-1:0]  p_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign stall = p_valid && !bus.resp_ready[p_id];

    always_comb begin
        gid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gid = IDW'(i);
        end
    end

    assign gaddr = bus.req_addr[int'(gid)*AW +: AW];

    always_comb begin
        bus.req_ready = '0;
        if (!reset && !stall) bus.req_ready = grant;
    end

    assign accept = |bus.req_ready;

    // stage A: pointer moves past the winner only on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (gid == IDW'(NREQ - 1)) rr_ptr <= '0;
            else                       rr_ptr <= gid + IDW'(1);
        end
    end

    // stage R: rd_sel only changes on an accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            rd_sel  <= '0;
        end else if (!stall) begin
            r_valid <= accept;
            if (accept) begin
                r_id   <= gid;
                rd_sel <= gaddr;
            end
        end
    end

    // stage P: a consumed response is overwritten with no bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid       <= 1'b0;
            p_id          <= '0;
            bus.resp_data <= '0;
        end else if (!stall) begin
            p_valid <= r_valid;
            if (r_valid) begin
                p_id          <= r_id;
                bus.resp_data <= rd_data;
            end
        end
    end

    always_comb begin
        bus.resp_valid = '0;
        if (p_valid) bus.resp_valid[p_id] = 1'b1;
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter with a 32-entry mux model.
// Inputs change at the falling edge; outputs are checked 1ns later.
module tb_rf_read_arbiter;
    import rf_read_arbiter_pkg::*;

    logic          clk;
    logic          reset;
    logic [4:0]    rd_sel;
    logic [31:0]   rd_data;
    logic [31:0]   regs [32];

    int total;
    int bad;

    rf_read_arbiter_if #(.NREQ(4), .AW(5), .DW(32)) bus ();

    rf_read_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    assign rd_data = regs[rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        bus.req_addr[i*5 +: 5] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [4:0] a2 [4];
    int         g;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i * 3);
        regs[0]  = 32'h0BAD_0000;
        regs[7]  = 32'hDEAD_BEEF;
        regs[31] = 32'h3131_3131;

        reset          = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_addr   = '0;
        bus.resp_ready = 4'b1111;

        // reset state
        @(negedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rvalid", 64'(bus.resp_valid), 64'h0);
        check("rst_sel", 64'(rd_sel), 64'h0);
        check("rst_data", 64'(bus.resp_data), 64'h0);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        // single read
        @(negedge clk);
        bus.req_valid = 4'b0001;
        set_addr(0, 5'd7);
        #1;
        check("single_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("single_sel", 64'(rd_sel), 64'd7);
        check("single_nov", 64'(bus.resp_valid), 64'h0);
        @(negedge clk);
        #1;
        check("single_rv", 64'(bus.resp_valid), 64'h1);
        check("single_data", 64'(bus.resp_data), 64'hDEADBEEF);
        @(negedge clk);
        #1;
        check("single_done", 64'(bus.resp_valid), 64'h0);

        // all four requesters continuously after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a2[i] = 5'(8 + 2 * i);
            set_addr(i, a2[i]);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) bus.req_valid = 4'b0000;
            #1;
            check($sformatf("rr_ready%0d", k), 64'(bus.req_ready),
                  (k <= 4) ? 64'(1 << (k % 4)) : 64'h0);
            if (k >= 1 && k <= 5) begin
                g = (k - 1) % 4;
                check($sformatf("rr_sel%0d", k), 64'(rd_sel), 64'(a2[g]));
            end
            if (k >= 2 && k <= 6) begin
                g = (k - 2) % 4;
                check($sformatf("rr_rv%0d", k), 64'(bus.resp_valid),
                      64'(1 << g));
                check($sformatf("rr_data%0d", k), 64'(bus.resp_data),
                      64'(regs[a2[g]]));
            end
            if (k == 7) check("rr_idle", 64'(bus.resp_valid), 64'h0);
            @(negedge clk);
        end

        // backpressure on requester 1 (pointer is now 1)
        set_addr(1, 5'd3);
        set_addr(2, 5'd4);
        set_addr(3, 5'd6);
        bus.req_valid = 4'b0110;
        #1;
        check("bp_ready0", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.resp_ready = 4'b1101;
        #1;
        check("bp_ready1", 64'(bus.req_ready), 64'b0100);
        check("bp_sel1", 64'(rd_sel), 64'd3);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        for (int k = 2; k <= 4; k++) begin
            #1;
            check($sformatf("bp_rv%0d", k), 64'(bus.resp_valid), 64'b0010);
            check($sformatf("bp_data%0d", k), 64'(bus.resp_data),
                  64'(regs[3]));
            check($sformatf("bp_ready%0d", k), 64'(bus.req_ready), 64'h0);
            check($sformatf("bp_sel%0d", k), 64'(rd_sel), 64'd4);
            @(negedge clk);
        end
        bus.resp_ready = 4'b1111;
        #1;
        check("bp_rel_ready", 64'(bus.req_ready), 64'b1000);
        check("bp_rel_rv", 64'(bus.resp_valid), 64'b0010);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("bp_drain_rv2", 64'(bus.resp_valid), 64'b0100);
        check("bp_drain_d2", 64'(bus.resp_data), 64'(regs[4]));
        check("bp_drain_sel", 64'(rd_sel), 64'd6);
        @(negedge clk);
        #1;
        check("bp_drain_rv3", 64'(bus.resp_valid), 64'b1000);
        check("bp_drain_d3", 64'(bus.resp_data), 64'(regs[6]));
        @(negedge clk);
        #1;
        check("bp_idle", 64'(bus.resp_valid), 64'h0);

        // move pointer to 3, then wrap with address 31 and 0
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_addr(2, 5'd9);
        #1;
        check("wr_prep", 64'(bus.req_ready), 64'b0100);
        @(negedge clk);
        bus.req_valid = 4'b1001;
        set_addr(3, 5'd31);
        set_addr(0, 5'd0);
        #1;
        check("wr_ptr3", 64'(dut.rr_ptr), 64'd3);
        check("wr_ready3", 64'(bus.req_ready), 64'b1000);
        check("wr_sel9", 64'(rd_sel), 64'd9);
        @(negedge clk);
        #1;
        check("wr_ptr0", 64'(dut.rr_ptr), 64'd0);
        check("wr_ready0", 64'(bus.req_ready), 64'b0001);
        check("wr_sel31", 64'(rd_sel), 64'd31);
        check("wr_rv2", 64'(bus.resp_valid), 64'b0100);
        check("wr_d9", 64'(bus.resp_data), 64'(regs[9]));
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("wr_ptr1", 64'(dut.rr_ptr), 64'd1);
        check("wr_sel0", 64'(rd_sel), 64'd0);
        check("wr_rv3", 64'(bus.resp_valid), 64'b1000);
        check("wr_d31", 64'(bus.resp_data), 64'h31313131);
        @(negedge clk);
        #1;
        check("wr_rv0", 64'(bus.resp_valid), 64'b0001);
        check("wr_d0", 64'(bus.resp_data), 64'h0BAD0000);

        // async reset with R and P occupied
        @(negedge clk);
        bus.req_valid = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("ar_pre_rv", 64'(bus.resp_valid), 64'b0010);
        #1;
        reset = 1'b1;
        #1;
        check("ar_rv", 64'(bus.resp_valid), 64'h0);
        check("ar_sel", 64'(rd_sel), 64'h0);
        check("ar_ptr", 64'(dut.rr_ptr), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("ar_quiet%0d", k), 64'(bus.resp_valid), 64'h0);
            @(negedge clk);
        end
        bus.req_valid = 4'b1001;
        #1;
        check("ar_first", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
